clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable, parametrised integer clock-enable divider. It generates a divided output of period N clock cycles. N and the output mode are changeable at run time through a valid/ready config port, and changes take effect glitch-free at the next period boundary. It sits beside the fixed divide-by-5 generator, serves as its general replacement for strobes and slow square waves, and adds a square mode with a defined duty cycle.

## Interface
- WIDTH, 8: width of divisor and counter; N max = 2^WIDTH-1
- DEFAULT_DIV, 5: divisor loaded at reset (must be >= 2)
- DEFAULT_MODE, 1: mode loaded at reset (0 = PULSE, 1 = SQUARE)
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; overrides every other input
- en  in  1  count enable; low freezes count, out, and mode/divisor in use
- cfg_valid  in  1  new config offered
- cfg_ready  out  1  shadow register free; transfer on cfg_valid && cfg_ready
- cfg_div  in  WIDTH  requested divisor N
- cfg_mode  in  1  requested mode
- out  out  1  divided output (registered)
- tick  out  1  one-cycle strobe on last cycle of each period (registered)
- count  out  WIDTH  current phase 0..N-1
- cfg_err  out  1  one-cycle pulse: the captured cfg_div was < 2 and was clamped to 2

## Operation
- Active divisor/mode registers (div_q, mode_q) and a one-entry shadow (div_s, mode_s, pend).
- Counter: when en=1, count increments and wraps from div_q-1 to 0. When en=0, count holds.
- Outputs are registered and always consistent with count in the same cycle:
  - tick = en_prev_cycle_advanced && count == div_q-1. Simply: tick = 1 iff count == div_q-1 and the counter advanced into that value.
  - PULSE: out = (count == div_q-1).
  - SQUARE: out = (count < H), H = div_q >> 1. High for floor(N/2) cycles, low for ceil(N/2) cycles. N even gives exactly 50% duty.
- Config FSM, two states:
  - RUN (pend=0, cfg_ready=1): a transfer captures cfg_div/cfg_mode into the shadow, sets cfg_err if cfg_div<2, and goes to PEND.
  - PEND (pend=1, cfg_ready=0): stays until a wrap occurs, i.e. en=1 and count==div_q-1. On that wrap, shadow copies into div_q/mode_q, count goes to 0, out is computed with the new values, and the FSM returns to RUN.
- A transfer in the same cycle as a wrap while in RUN does not apply at that wrap. It applies at the following wrap.
- Clamp: a cfg_div of 0 or 1 is stored as 2.
- Arithmetic is unsigned WIDTH-bit. count never exceeds div_q-1, so no overflow occurs.

## Timing
- Reset values:
  - count = 0, div_q = DEFAULT_DIV, mode_q = DEFAULT_MODE
  - out = (DEFAULT_MODE == SQUARE), tick = 0
  - cfg_ready = 1, pend = 0, cfg_err = 0
- Reset asserted mid-period or mid-PEND discards the shadow and restores the defaults above on the next edge.
- Latency: cfg_err rises on the edge after the transfer. The new divisor/mode affects out on the first cycle of the next period. cfg_ready is 1 on the cycle after the applying wrap.
- en low in PEND: config is held indefinitely and never applied until counting resumes and wraps.
- Period from the first rising edge of out = exactly div_q cycles while en=1.

## Structure
- Package clk_div_pkg holds:
  - mode constants MODE_PULSE = 1'b0, MODE_SQUARE = 1'b1
  - MIN_DIV = 2
  - FSM state encoding S_RUN, S_PEND
- Single module. No sub-module is warranted: the shadow/FSM is a few registers and the counter is one adder.

## Test plan
- Reset defaults (N=5, SQUARE), en=1 → out pattern 1,1,0,0,0 repeating; tick on count=4 only; cfg_ready=1.
- Config N=4, PULSE sent at count=1 → cfg_ready low until the wrap after count=4. Then out=0,0,0,1 repeating, period 4, and tick coincides with out.
- Config cfg_div=1 → cfg_err pulses once, one cycle after transfer. Applied N=2: SQUARE out alternates 1,0.
- Transfer exactly on the count=N-1 cycle → old N is kept for one more full period, then the new N applies. A second cfg_valid during PEND is not accepted (cfg_ready=0).
- en dropped for 7 cycles at count=2 → count, out, and tick frozen (tick=0). Resuming continues from 3 with no lost or extra cycle.
- reset pulsed while in PEND with N=9 pending → after reset, N=5, SQUARE, cfg_ready=1, and the pending config is never applied.

Source files
------------

// File: rtl/clk_div_prog_pkg.sv
// Shared constants and FSM encoding for the programmable clock-enable divider.
package clk_div_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;
  localparam int   MIN_DIV     = 2;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_PEND = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/clk_div_prog_if.sv
// Config handshake bundle: one-entry valid/ready port plus the clamp error strobe.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_mode;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, output cfg_mode,
                  input  cfg_ready, input  cfg_err);
  modport slave  (input  cfg_valid, input  cfg_div, input  cfg_mode,
                  output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_prog.sv
// Programmable divide-by-N clock enable with PULSE/SQUARE output; new config
// is parked in a shadow and swapped in only at a period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   DEFAULT_DIV  = 5,
  parameter logic DEFAULT_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  clk_div_prog_if.slave    cfg,
  output logic             out,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_D   = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  cfg_state_e       state_q, state_n;
  logic [WIDTH-1:0] div_q, div_s, div_s_n, div_n, cnt_n;
  logic             mode_q, mode_s, mode_s_n, mode_n;
  logic             err_q, err_n;
  logic             xfer, wrap, apply, out_n, tick_n;

  assign cfg.cfg_ready = (state_q == S_RUN);
  assign cfg.cfg_err   = err_q;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign wrap          = en && (count == div_q - ONE);

  // A transfer landing on a wrap cycle is only captured here; it cannot
  // apply until the next wrap because apply requires S_PEND.
  always_comb begin
    state_n  = state_q;
    div_s_n  = div_s;
    mode_s_n = mode_s;
    err_n    = 1'b0;
    apply    = 1'b0;
    case (state_q)
      S_RUN: if (xfer) begin
        state_n  = S_PEND;
        div_s_n  = (cfg.cfg_div < MIN_D) ? MIN_D : cfg.cfg_div;
        mode_s_n = cfg.cfg_mode;
        err_n    = (cfg.cfg_div < MIN_D);
      end
      S_PEND: if (wrap) begin
        apply   = 1'b1;
        state_n = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  // Outputs are computed from the post-edge count/divisor so they stay
  // aligned with count in the same cycle.
  always_comb begin
    div_n  = apply ? div_s  : div_q;
    mode_n = apply ? mode_s : mode_q;
    cnt_n  = count;
    if (en) cnt_n = wrap ? '0 : count + ONE;
    out_n  = 1'b0;
    if (mode_n == MODE_PULSE) out_n = (cnt_n == div_n - ONE);
    else                      out_n = (cnt_n < (div_n >> 1));
    tick_n = en && (cnt_n == div_n - ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      count   <= '0;
      div_q   <= DEF_DIV;
      mode_q  <= DEFAULT_MODE;
      div_s   <= DEF_DIV;
      mode_s  <= DEFAULT_MODE;
      out     <= (DEFAULT_MODE == MODE_SQUARE);
      tick    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      count   <= cnt_n;
      div_q   <= div_n;
      mode_q  <= mode_n;
      div_s   <= div_s_n;
      mode_s  <= mode_s_n;
      out     <= out_n;
      tick    <= tick_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues hand-derived per-cycle
// expectations, a monitor pops and compares them after every clock edge.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int W = 8;
  localparam logic [15:0] P5 = 16'b00011;   // N=5 SQUARE: 1,1,0,0,0
  localparam logic [15:0] P4 = 16'b1000;    // N=4 PULSE:  0,0,0,1
  localparam logic [15:0] P2 = 16'b01;      // N=2 SQUARE: 1,0
  localparam logic [15:0] P6 = 16'b000111;  // N=6 SQUARE: 1,1,1,0,0,0

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         out, tick;
  logic [W-1:0] count;

  clk_div_prog_if #(.WIDTH(W)) cfg_if ();

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(5), .DEFAULT_MODE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .cfg   (cfg_if),
    .out   (out),
    .tick  (tick),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         o;
    logic         t;
    logic         r;
    logic         e;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ph     = 0;

  task automatic chk1(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      ex = q.pop_front();
      chk1("count",     count,            ex.cnt);
      chk1("out",       W'(out),          W'(ex.o));
      chk1("tick",      W'(tick),         W'(ex.t));
      chk1("cfg_ready", W'(cfg_if.cfg_ready), W'(ex.r));
      chk1("cfg_err",   W'(cfg_if.cfg_err),   W'(ex.e));
    end
  end

  // nw: divisor governing the wrap on this edge; nn/pat: divisor and out
  // pattern in force after the edge.
  task automatic step(input bit e, input bit v, input logic [W-1:0] d, input bit m,
                      input int nw, input int nn, input logic [15:0] pat,
                      input bit r, input bit er);
    exp_t x;
    @(negedge clk);
    reset = 1'b0; en = e;
    cfg_if.cfg_valid = v; cfg_if.cfg_div = d; cfg_if.cfg_mode = m;
    @(posedge clk);
    if (e) ph = (ph == nw - 1) ? 0 : ph + 1;
    x.cnt = W'(ph);
    x.o   = pat[ph];
    x.t   = e && (ph == nn - 1);
    x.r   = r;
    x.e   = er;
    q.push_back(x);
  endtask

  task automatic run(input int n, input logic [15:0] pat, input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b1, 1'b0, '0, 1'b0, n, n, pat, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input bit e);
    exp_t x;
    @(negedge clk);
    reset = 1'b1; en = e; cfg_if.cfg_valid = 1'b0;
    @(posedge clk);
    ph = 0;
    x.cnt = '0; x.o = 1'b1; x.t = 1'b0; x.r = 1'b1; x.e = 1'b0;
    q.push_back(x);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_mode  = 1'b0;

    // reset defaults, then N=5 SQUARE free-running
    do_reset(1'b0);
    do_reset(1'b1);
    run(5, P5, 10);

    // N=4 PULSE sent at count=1; held off until the wrap after count=4
    step(1, 0, 0, 0,          5, 5, P5, 1, 0);
    step(1, 1, 4, MODE_PULSE, 5, 5, P5, 0, 0);
    step(1, 0, 0, 0,          5, 5, P5, 0, 0);
    step(1, 0, 0, 0,          5, 5, P5, 0, 0);
    step(1, 0, 0, 0,          5, 4, P4, 1, 0);
    run(4, P4, 8);

    // cfg_div=1 clamps to 2 with a single cfg_err pulse
    step(1, 1, 1, MODE_SQUARE, 4, 4, P4, 0, 1);
    step(1, 0, 0, 0,           4, 4, P4, 0, 0);
    step(1, 0, 0, 0,           4, 4, P4, 0, 0);
    step(1, 0, 0, 0,           4, 2, P2, 1, 0);
    run(2, P2, 6);

    // transfer on the last cycle: old N survives one more period; a second
    // offer during PEND is refused
    step(1, 0, 0, 0,           2, 2, P2, 1, 0);
    step(1, 1, 6, MODE_SQUARE, 2, 2, P2, 0, 0);
    step(1, 1, 3, MODE_PULSE,  2, 2, P2, 0, 0);
    step(1, 1, 3, MODE_PULSE,  2, 6, P6, 1, 0);
    run(6, P6, 12);

    // en low for 7 cycles at count=2, then low again on count=N-1
    run(6, P6, 2);
    repeat (7) step(0, 0, 0, 0, 6, 6, P6, 1, 0);
    run(6, P6, 3);
    repeat (2) step(0, 0, 0, 0, 6, 6, P6, 1, 0);
    run(6, P6, 1);

    // N=9 pending (held through en low) is discarded by reset
    step(1, 1, 9, MODE_PULSE, 6, 6, P6, 0, 0);
    step(1, 0, 0, 0,          6, 6, P6, 0, 0);
    repeat (3) step(0, 0, 0, 0, 6, 6, P6, 0, 0);
    do_reset(1'b1);
    run(5, P5, 12);

    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
